// File: rtl/sll_shifter_seq.sv
// Iterative logical-left shifter: one log2 stage (1,2,4,8,16) per clock, valid/ready on both sides.
// Optional macro SLL_SHIFTER_EARLY_DONE_EN finishes as soon as no shift-amount bits remain.
module sll_shifter_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_result,
    output logic               o_busy
);

    localparam int CNT_W = $clog2(SHAMT_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHAMT_W:0]   stage_amt;

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        // Stage cnt shifts by 2**cnt; rem[0] always holds the shamt bit for the current stage.
        stage_amt = (SHAMT_W + 1)'(1) << cnt_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    res_d   = i_data;
                    rem_d   = i_shamt;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SLL_SHIFTER_EARLY_DONE_EN
                    if (i_shamt == '0) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            SHIFT: begin
                if (rem_q[0]) begin
                    res_d = res_q << stage_amt;
                end
                rem_d = rem_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SHAMT_W - 1)) begin
                    state_d = DONE;
                end
`ifdef SLL_SHIFTER_EARLY_DONE_EN
                if (rem_d == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign o_result = res_q;

endmodule
